// File: rtl/signature_test_sequencer.sv
// -----------------------------------------------------------------------------
// signature_test_sequencer
//
// Built-in signature tester for an 8-bit circuit under test (CUT). A start
// request runs two passes, one per latched seed. Each pass:
//   - clears the CUT for one cycle,
//   - sweeps the stimulus counter over 0..NUM_VECTORS-1,
//   - compresses the CUT responses into a 16-bit signature using
//     scramble (xor with seed), 8-bit add and a 16-bit rotate,
//   - compares the signature with the latched golden value.
//
// Ports:
//   clk         system clock, rising edge
//   clear       synchronous active-high reset
//   start       two-pass test request, sampled only in IDLE
//   seed_a/b    scrambler seeds for pass A/B, latched at start
//   golden_a/b  expected signatures for pass A/B, latched at start
//   cut_output  CUT response (RESP_LATENCY cycles behind stimulus)
//   stimulus    CUT input (counter value)
//   cut_clear   CUT reset: clear OR state FLUSH
//   busy        high in every state except IDLE
//   done        one-cycle pulse in state DONE
//   sig_a/b     captured signatures
//   pass_a/b    signature equals golden, valid after DONE
// -----------------------------------------------------------------------------
module signature_test_sequencer #(
    parameter int NUM_VECTORS  = 255,
    parameter int RESP_LATENCY = 0
) (
    input  logic        clk,
    input  logic        clear,
    input  logic        start,
    input  logic [7:0]  seed_a,
    input  logic [7:0]  seed_b,
    input  logic [15:0] golden_a,
    input  logic [15:0] golden_b,
    input  logic [7:0]  cut_output,
    output logic [7:0]  stimulus,
    output logic        cut_clear,
    output logic        busy,
    output logic        done,
    output logic [15:0] sig_a,
    output logic [15:0] sig_b,
    output logic        pass_a,
    output logic        pass_b
);

    if (NUM_VECTORS < 1 || NUM_VECTORS > 255 || RESP_LATENCY < 0 || RESP_LATENCY > 3) begin : g_param_check
        $error("signature_test_sequencer: NUM_VECTORS must be 1..255 and RESP_LATENCY 0..3");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_FLUSH,
        S_RUN,
        S_DRAIN,
        S_CHECK,
        S_DONE
    } state_t;

    localparam logic [7:0] LAST_STIM = 8'(NUM_VECTORS - 1);
    localparam logic [1:0] LAST_DRAIN = 2'(RESP_LATENCY - 1);

    state_t      state_reg;
    logic [7:0]  stim_reg;
    logic [15:0] acc_reg;
    logic [7:0]  seed_a_reg;
    logic [7:0]  seed_b_reg;
    logic [15:0] golden_a_reg;
    logic [15:0] golden_b_reg;
    logic        pass_sel_reg;   // 0 = pass A, 1 = pass B
    logic [1:0]  drain_cnt_reg;
    logic        busy_reg;
    logic        done_reg;
    logic [15:0] sig_a_reg;
    logic [15:0] sig_b_reg;
    logic        pass_a_reg;
    logic        pass_b_reg;

    logic        run_tag;
    logic        resp_valid;
    logic [7:0]  seed_sel;
    logic [7:0]  scr;
    logic [7:0]  sum;
    logic [15:0] acc_next;

    // Every RUN cycle presents exactly one valid stimulus.
    assign run_tag = (state_reg == S_RUN);

    // The valid tag travels alongside the CUT so the accumulator samples
    // cut_output exactly when the response to a tagged stimulus arrives.
    if (RESP_LATENCY == 0) begin : g_no_latency
        assign resp_valid = run_tag;
    end else begin : g_latency
        logic [RESP_LATENCY-1:0] vld_pipe_reg;

        always_ff @(posedge clk) begin
            if (clear || state_reg == S_FLUSH) begin
                vld_pipe_reg <= '0;
            end else begin
                vld_pipe_reg <= (vld_pipe_reg << 1) | RESP_LATENCY'(run_tag);
            end
        end

        assign resp_valid = vld_pipe_reg[RESP_LATENCY-1];
    end

    // Compression step: scramble, add low byte (carry dropped), rotate left.
    always_comb begin
        seed_sel = pass_sel_reg ? seed_b_reg : seed_a_reg;
        scr      = seed_sel ^ cut_output;
        sum      = acc_reg[7:0] + scr;
        acc_next = {acc_reg[14:8], sum, acc_reg[15]};
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            state_reg     <= S_IDLE;
            stim_reg      <= '0;
            acc_reg       <= '0;
            seed_a_reg    <= '0;
            seed_b_reg    <= '0;
            golden_a_reg  <= '0;
            golden_b_reg  <= '0;
            pass_sel_reg  <= 1'b0;
            drain_cnt_reg <= '0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
            sig_a_reg     <= '0;
            sig_b_reg     <= '0;
            pass_a_reg    <= 1'b0;
            pass_b_reg    <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            if (resp_valid) begin
                acc_reg <= acc_next;
            end

            case (state_reg)
                S_IDLE: begin
                    if (start) begin
                        seed_a_reg    <= seed_a;
                        seed_b_reg    <= seed_b;
                        golden_a_reg  <= golden_a;
                        golden_b_reg  <= golden_b;
                        pass_sel_reg  <= 1'b0;
                        sig_a_reg     <= '0;
                        sig_b_reg     <= '0;
                        pass_a_reg    <= 1'b0;
                        pass_b_reg    <= 1'b0;
                        stim_reg      <= '0;
                        acc_reg       <= '0;
                        drain_cnt_reg <= '0;
                        busy_reg      <= 1'b1;
                        state_reg     <= S_FLUSH;
                    end
                end

                S_FLUSH: begin
                    stim_reg  <= '0;
                    acc_reg   <= '0;
                    state_reg <= S_RUN;
                end

                S_RUN: begin
                    // After the last vector the counter parks at NUM_VECTORS.
                    stim_reg <= stim_reg + 8'd1;
                    if (stim_reg == LAST_STIM) begin
                        drain_cnt_reg <= '0;
                        state_reg     <= (RESP_LATENCY == 0) ? S_CHECK : S_DRAIN;
                    end
                end

                S_DRAIN: begin
                    drain_cnt_reg <= drain_cnt_reg + 2'd1;
                    if (drain_cnt_reg == LAST_DRAIN) begin
                        state_reg <= S_CHECK;
                    end
                end

                S_CHECK: begin
                    if (!pass_sel_reg) begin
                        sig_a_reg    <= acc_reg;
                        pass_a_reg   <= (acc_reg == golden_a_reg);
                        pass_sel_reg <= 1'b1;
                        stim_reg     <= '0;
                        acc_reg      <= '0;
                        state_reg    <= S_FLUSH;
                    end else begin
                        sig_b_reg  <= acc_reg;
                        pass_b_reg <= (acc_reg == golden_b_reg);
                        done_reg   <= 1'b1;
                        state_reg  <= S_DONE;
                    end
                end

                S_DONE: begin
                    busy_reg  <= 1'b0;
                    state_reg <= S_IDLE;
                end

                default: begin
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

    assign stimulus  = stim_reg;
    assign cut_clear = clear | (state_reg == S_FLUSH);
    assign busy      = busy_reg;
    assign done      = done_reg;
    assign sig_a     = sig_a_reg;
    assign sig_b     = sig_b_reg;
    assign pass_a    = pass_a_reg;
    assign pass_b    = pass_b_reg;

endmodule

// File: tb/tb_signature_test_sequencer.sv
// -----------------------------------------------------------------------------
// tb_signature_test_sequencer
//
// Three sequencer instances:
//   dut 0: defaults, CUT is either all-zero or identity (cut_mode)
//   dut 1: NUM_VECTORS=2, all-zero CUT
//   dut 2: RESP_LATENCY=2, identity CUT delayed by two registers
// Expected signatures are pushed to a scoreboard queue when a test is
// started and popped when the instance drops busy.
// -----------------------------------------------------------------------------
module tb_signature_test_sequencer;

    typedef struct packed {
        logic [15:0] sa;
        logic [15:0] sb;
        logic        pa;
        logic        pb;
    } exp_t;

    logic        clk;
    logic        clear;
    logic [7:0]  seed_a;
    logic [7:0]  seed_b;
    logic [15:0] golden_a;
    logic [15:0] golden_b;
    logic        cut_mode;

    logic        start_v    [3];
    logic [7:0]  cut_w      [3];
    logic [7:0]  stim_w     [3];
    logic        cut_clear_w[3];
    logic        busy_w     [3];
    logic        done_w     [3];
    logic [15:0] sig_a_w    [3];
    logic [15:0] sig_b_w    [3];
    logic        pass_a_w   [3];
    logic        pass_b_w   [3];

    logic [7:0]  dly1;
    logic [7:0]  dly2;

    exp_t        sb_q[$];
    int          total;
    int          bad;
    logic [7:0]  stim_exp1 [9];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign cut_w[0] = cut_mode ? stim_w[0] : 8'h00;
    assign cut_w[1] = 8'h00;
    assign cut_w[2] = dly2;

    always @(posedge clk) begin
        dly1 <= stim_w[2];
        dly2 <= dly1;
    end

    signature_test_sequencer dut0 (
        .clk(clk), .clear(clear), .start(start_v[0]),
        .seed_a(seed_a), .seed_b(seed_b), .golden_a(golden_a), .golden_b(golden_b),
        .cut_output(cut_w[0]), .stimulus(stim_w[0]), .cut_clear(cut_clear_w[0]),
        .busy(busy_w[0]), .done(done_w[0]), .sig_a(sig_a_w[0]), .sig_b(sig_b_w[0]),
        .pass_a(pass_a_w[0]), .pass_b(pass_b_w[0])
    );

    signature_test_sequencer #(.NUM_VECTORS(2)) dut1 (
        .clk(clk), .clear(clear), .start(start_v[1]),
        .seed_a(seed_a), .seed_b(seed_b), .golden_a(golden_a), .golden_b(golden_b),
        .cut_output(cut_w[1]), .stimulus(stim_w[1]), .cut_clear(cut_clear_w[1]),
        .busy(busy_w[1]), .done(done_w[1]), .sig_a(sig_a_w[1]), .sig_b(sig_b_w[1]),
        .pass_a(pass_a_w[1]), .pass_b(pass_b_w[1])
    );

    signature_test_sequencer #(.RESP_LATENCY(2)) dut2 (
        .clk(clk), .clear(clear), .start(start_v[2]),
        .seed_a(seed_a), .seed_b(seed_b), .golden_a(golden_a), .golden_b(golden_b),
        .cut_output(cut_w[2]), .stimulus(stim_w[2]), .cut_clear(cut_clear_w[2]),
        .busy(busy_w[2]), .done(done_w[2]), .sig_a(sig_a_w[2]), .sig_b(sig_b_w[2]),
        .pass_a(pass_a_w[2]), .pass_b(pass_b_w[2])
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference signature: n vectors, response is 0 or the stimulus value.
    function automatic logic [15:0] model_sig(input logic [7:0] seed, input bit ident, input int n);
        logic [15:0] acc;
        logic [7:0]  resp;
        logic [7:0]  s;
        acc = 16'h0000;
        for (int v = 0; v < n; v++) begin
            resp = ident ? 8'(v) : 8'h00;
            s    = acc[7:0] + (seed ^ resp);
            acc  = {acc[14:8], s, acc[15]};
        end
        return acc;
    endfunction

    // disturb: 0 none, 1 start pulses in RUN and in pass-A CHECK,
    //          2 seed/golden inputs changed during pass A
    task automatic run_test(input int d, input logic [15:0] ea, input logic [15:0] eb,
                            input logic pa, input logic pb, input int exp_busy,
                            input int disturb, input string name);
        exp_t e;
        exp_t got;
        int   busy_cnt;
        int   done_cnt;
        int   done_at;
        int   cc_hi;
        int   cc_rise;
        logic cc_prev;
        int   check_cyc;

        e.sa = ea; e.sb = eb; e.pa = pa; e.pb = pb;
        sb_q.push_back(e);
        check_cyc = (exp_busy - 1) / 2;

        start_v[d] = 1'b1;
        tick();
        start_v[d] = 1'b0;
        busy_cnt = 0; done_cnt = 0; done_at = 0; cc_hi = 0; cc_rise = 0; cc_prev = 1'b0;
        while (busy_w[d] && busy_cnt < 3000) begin
            busy_cnt++;
            if (done_w[d]) begin
                done_cnt++;
                done_at = busy_cnt;
            end
            if (cut_clear_w[d]) begin
                cc_hi++;
                if (!cc_prev) cc_rise++;
            end
            cc_prev = cut_clear_w[d];
            if (d == 1 && busy_cnt <= 9)
                check($sformatf("%s_stim_c%0d", name, busy_cnt), 32'(stim_w[1]), 32'(stim_exp1[busy_cnt-1]));
            if (d == 1 && busy_cnt == 3)
                check($sformatf("%s_acc_step1", name), 32'(dut1.acc_reg), 32'h0002);
            if (d == 1 && busy_cnt == 4)
                check($sformatf("%s_acc_step2", name), 32'(dut1.acc_reg), 32'h0006);
            start_v[d] = (disturb == 1) && (busy_cnt == 10 || busy_cnt == check_cyc);
            if (disturb == 2 && busy_cnt == 20) begin
                seed_a   = ~seed_a;
                golden_a = 16'h1234;
            end
            tick();
        end
        start_v[d] = 1'b0;

        check({name, "_busy_len"}, busy_cnt, exp_busy);
        check({name, "_done_count"}, done_cnt, 1);
        check({name, "_done_cycle"}, done_at, exp_busy);
        check({name, "_cut_clear_cycles"}, cc_hi, 2);
        check({name, "_cut_clear_pulses"}, cc_rise, 2);

        got = sb_q.pop_front();
        check({name, "_sig_a"}, 32'(sig_a_w[d]), 32'(got.sa));
        check({name, "_sig_b"}, 32'(sig_b_w[d]), 32'(got.sb));
        check({name, "_pass_a"}, 32'(pass_a_w[d]), 32'(got.pa));
        check({name, "_pass_b"}, 32'(pass_b_w[d]), 32'(got.pb));
        $display("test %s: busy=%0d sig_a=%04h sig_b=%04h pass_a=%0b pass_b=%0b",
                 name, busy_cnt, sig_a_w[d], sig_b_w[d], pass_a_w[d], pass_b_w[d]);
    endtask

    initial begin
        logic [15:0] ga;
        logic [15:0] gb;
        int          g;
        logic        seen;

        total = 0;
        bad = 0;
        stim_exp1 = '{8'd0, 8'd0, 8'd1, 8'd2, 8'd0, 8'd0, 8'd1, 8'd2, 8'd2};
        for (int i = 0; i < 3; i++) start_v[i] = 1'b0;
        seed_a = 8'h00; seed_b = 8'h00; golden_a = 16'h0000; golden_b = 16'h0000;
        cut_mode = 1'b0;

        // Reset state
        clear = 1'b1;
        tick();
        tick();
        check("reset_cut_clear_high", 32'(cut_clear_w[0]), 32'd1);
        check("reset_busy", 32'(busy_w[0]), 32'd0);
        check("reset_done", 32'(done_w[0]), 32'd0);
        check("reset_stimulus", 32'(stim_w[0]), 32'd0);
        check("reset_sigs", {sig_a_w[0], sig_b_w[0]}, 32'd0);
        check("reset_pass", {30'd0, pass_a_w[0], pass_b_w[0]}, 32'd0);
        clear = 1'b0;
        #1;
        check("idle_cut_clear_low", 32'(cut_clear_w[0]), 32'd0);
        tick();

        // Zero CUT, zero seeds and goldens
        run_test(0, 16'h0000, 16'h0000, 1'b1, 1'b1, 515, 0, "zero");

        // Two vectors, hand-computed signature
        seed_a = 8'h01; golden_a = 16'h0006; seed_b = 8'h00; golden_b = 16'h0001;
        run_test(1, 16'h0006, 16'h0000, 1'b1, 1'b0, 9, 0, "nv2");

        // Identity CUT without and with response latency, same seeds
        cut_mode = 1'b1;
        seed_a = 8'hAA; seed_b = 8'hFF;
        ga = model_sig(8'hAA, 1'b1, 255);
        gb = model_sig(8'hFF, 1'b1, 255);
        golden_a = ga; golden_b = gb;
        run_test(0, ga, gb, 1'b1, 1'b1, 515, 1, "ident_lat0_startpulses");
        golden_a = ga; golden_b = gb;
        run_test(2, ga, gb, 1'b1, 1'b1, 519, 0, "ident_lat2");

        // Seed and golden inputs disturbed mid-pass
        seed_a = 8'hAA; seed_b = 8'hFF; golden_a = ga; golden_b = gb;
        run_test(0, ga, gb, 1'b1, 1'b1, 515, 2, "seed_change");

        // Mid-run clear at stimulus 0x40 of pass A
        seed_a = 8'hAA; golden_a = ga;
        start_v[0] = 1'b1;
        tick();
        start_v[0] = 1'b0;
        g = 0;
        while (stim_w[0] != 8'h40 && g < 400) begin
            g++;
            tick();
        end
        check("midrun_reach_0x40", 32'(stim_w[0]), 32'h40);
        clear = 1'b1;
        #1;
        check("midrun_cut_clear", 32'(cut_clear_w[0]), 32'd1);
        tick();
        clear = 1'b0;
        check("midrun_busy", 32'(busy_w[0]), 32'd0);
        check("midrun_stimulus", 32'(stim_w[0]), 32'd0);
        check("midrun_sigs", {sig_a_w[0], sig_b_w[0]}, 32'd0);
        check("midrun_pass", {30'd0, pass_a_w[0], pass_b_w[0]}, 32'd0);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            seen = seen | done_w[0] | busy_w[0];
            tick();
        end
        check("midrun_no_done_no_busy", 32'(seen), 32'd0);
        $display("test midrun_clear: busy=%0b stimulus=%02h", busy_w[0], stim_w[0]);

        // clear and start on the same edge
        clear = 1'b1;
        start_v[0] = 1'b1;
        tick();
        clear = 1'b0;
        start_v[0] = 1'b0;
        check("clear_start_busy", 32'(busy_w[0]), 32'd0);
        tick();
        check("clear_start_busy_after", 32'(busy_w[0]), 32'd0);
        $display("test clear_with_start: busy=%0b", busy_w[0]);

        // A later start completes normally
        cut_mode = 1'b0;
        seed_a = 8'h00; seed_b = 8'h00; golden_a = 16'h0000; golden_b = 16'h0000;
        run_test(0, 16'h0000, 16'h0000, 1'b1, 1'b1, 515, 0, "after_clear");

        // start held high re-triggers one cycle after DONE
        start_v[1] = 1'b1;
        tick();
        g = 0;
        while (busy_w[1] && g < 50) begin
            g++;
            tick();
        end
        check("retrig_busy_len", g, 9);
        check("retrig_idle_gap", 32'(busy_w[1]), 32'd0);
        tick();
        check("retrig_restart", 32'(busy_w[1]), 32'd1);
        start_v[1] = 1'b0;
        g = 0;
        while (busy_w[1] && g < 50) begin
            g++;
            tick();
        end
        check("retrig_second_len", g, 9);
        $display("test retrigger: second busy=%0d", g);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
